// File: rtl/ddr_local_responder_if.sv
// Local command/data bus between a DDR burst master and the memory side.
// Signal names follow the DDR-IP local interface so existing masters bind directly.
interface ddr_local_responder_if #(
    parameter int MEM_DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH      = 25,
    parameter int LOCAL_SIZE_BITS = 3
);
    logic                          LOCAL_INITIAL_DONE;
    logic                          LOCAL_READY;
    logic [ADDR_WIDTH-1:0]         LOCAL_ADDR;
    logic [LOCAL_SIZE_BITS-1:0]    LOCAL_SIZE;
    logic                          LOCAL_BURSTBEGIN;
    logic                          LOCAL_WRITE_REQ;
    logic [MEM_DATA_WIDTH-1:0]     LOCAL_WDATA;
    logic [MEM_DATA_WIDTH/8-1:0]   LOCAL_BE;
    logic                          LOCAL_READ_REQ;
    logic [MEM_DATA_WIDTH-1:0]     LOCAL_RDATA;
    logic                          LOCAL_RDATA_VALID;
    logic                          PROTO_ERR;

    modport master (
        input  LOCAL_INITIAL_DONE, LOCAL_READY, LOCAL_RDATA, LOCAL_RDATA_VALID, PROTO_ERR,
        output LOCAL_ADDR, LOCAL_SIZE, LOCAL_BURSTBEGIN, LOCAL_WRITE_REQ, LOCAL_WDATA,
               LOCAL_BE, LOCAL_READ_REQ
    );

    modport slave (
        output LOCAL_INITIAL_DONE, LOCAL_READY, LOCAL_RDATA, LOCAL_RDATA_VALID, PROTO_ERR,
        input  LOCAL_ADDR, LOCAL_SIZE, LOCAL_BURSTBEGIN, LOCAL_WRITE_REQ, LOCAL_WDATA,
               LOCAL_BE, LOCAL_READ_REQ
    );
endinterface

// File: rtl/ddr_local_responder.sv
// Memory-side stand-in for the DDR controller local port: on-chip RAM, fixed-latency
// read pipeline, queued read commands and a rotating READY backpressure pattern.
module ddr_local_responder #(
    parameter int          MEM_DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH      = 25,
    parameter int          LOCAL_SIZE_BITS = 3,
    parameter int          MEM_DEPTH_BITS  = 10,
    parameter int          INIT_CYCLES     = 16,
    parameter int          RD_LATENCY      = 4,
    parameter int          CMD_FIFO_DEPTH  = 4,
    parameter logic [7:0]  READY_PATTERN   = 8'hFF
) (
    input  logic                  MEM_CLK,
    input  logic                  RST,
    ddr_local_responder_if.slave  bus
);
    localparam int BE_WIDTH   = MEM_DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(INIT_CYCLES + 1);
    localparam int FIFO_PTR_W = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int FIFO_CNT_W = $clog2(CMD_FIFO_DEPTH + 1);

    typedef logic [MEM_DEPTH_BITS-1:0]  ram_addr_t;
    typedef logic [LOCAL_SIZE_BITS-1:0] size_t;
    typedef logic [FIFO_PTR_W-1:0]      ptr_t;
    typedef struct packed { ram_addr_t addr; size_t size; } rd_cmd_t;
    typedef enum logic { WR_IDLE, WR_BURST } wr_state_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(CMD_FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [MEM_DATA_WIDTH-1:0] mem [2**MEM_DEPTH_BITS];
    rd_cmd_t                   fifo_mem [CMD_FIFO_DEPTH];

    logic [CNT_W-1:0]      init_cnt;
    logic                  init_done;
    logic [2:0]            pat_idx;
    wr_state_t             wr_state, wr_state_nxt;
    ram_addr_t             base, base_nxt;
    size_t                 len, len_nxt, idx, idx_nxt, idx_inc;
    ptr_t                  wr_ptr, rd_ptr;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic                  rd_busy;
    ram_addr_t             rd_addr;
    size_t                 rd_left;
    logic [MEM_DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0]     pipe_valid;
    logic                  proto_err;

    logic      ready, wr_acc, rd_acc, size_ok, fifo_empty;
    logic      ram_we, push, err_set, eng_free, take, pop, fifo_wr;
    ram_addr_t addr_lo, ram_waddr;
    rd_cmd_t   next_cmd;

    assign addr_lo    = bus.LOCAL_ADDR[MEM_DEPTH_BITS-1:0];
    assign size_ok    = (bus.LOCAL_SIZE != '0);
    assign fifo_empty = (fifo_cnt == '0);
    assign ready      = init_done & (fifo_cnt < FIFO_CNT_W'(CMD_FIFO_DEPTH)) & READY_PATTERN[pat_idx];
    // Nothing is accepted on a reset edge even if READY was high going into it.
    assign wr_acc     = ready & ~RST & bus.LOCAL_WRITE_REQ;
    assign rd_acc     = ready & ~RST & bus.LOCAL_READ_REQ;
    assign idx_inc    = idx + size_t'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
            pat_idx   <= '0;
        end else if (!init_done) begin
            if (init_cnt == CNT_W'(INIT_CYCLES)) init_done <= 1'b1;
            else                                 init_cnt  <= init_cnt + CNT_W'(1);
        end else begin
            pat_idx <= pat_idx + 3'd1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        wr_state_nxt = wr_state;
        base_nxt     = base;
        len_nxt      = len;
        idx_nxt      = idx;
        ram_we       = 1'b0;
        ram_waddr    = '0;
        push         = 1'b0;
        err_set      = 1'b0;
        if (wr_acc) begin
            err_set = rd_acc;
            if (bus.LOCAL_BURSTBEGIN) begin
                if (wr_state == WR_BURST) err_set = 1'b1;
                if (!size_ok) begin
                    err_set      = 1'b1;
                    wr_state_nxt = WR_IDLE;
                end else begin
                    ram_we       = 1'b1;
                    ram_waddr    = addr_lo;
                    base_nxt     = addr_lo;
                    len_nxt      = bus.LOCAL_SIZE;
                    idx_nxt      = size_t'(1);
                    wr_state_nxt = (bus.LOCAL_SIZE > size_t'(1)) ? WR_BURST : WR_IDLE;
                end
            end else if (wr_state == WR_IDLE) begin
                err_set = 1'b1;
            end else begin
                ram_we    = 1'b1;
                ram_waddr = base + ram_addr_t'(idx);
                idx_nxt   = idx_inc;
                if (idx_inc == len) wr_state_nxt = WR_IDLE;
            end
        end else if (rd_acc) begin
            if (!bus.LOCAL_BURSTBEGIN || !size_ok || wr_state == WR_BURST) err_set = 1'b1;
            else                                                            push    = 1'b1;
        end
    end

    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            wr_state  <= WR_IDLE;
            base      <= '0;
            len       <= '0;
            idx       <= '0;
            proto_err <= 1'b0;
        end else begin
            wr_state  <= wr_state_nxt;
            base      <= base_nxt;
            len       <= len_nxt;
            idx       <= idx_nxt;
            if (err_set) proto_err <= 1'b1;
        end
    end

    // The engine reloads on its last issue cycle, so consecutive bursts stream gaplessly;
    // an empty FIFO lets a fresh command go straight to the engine.
    always_comb begin
        eng_free = !rd_busy || (rd_left == size_t'(1));
        take     = eng_free && (!fifo_empty || push);
        pop      = take && !fifo_empty;
        fifo_wr  = push && !(take && fifo_empty);
        next_cmd = fifo_empty ? rd_cmd_t'{addr: addr_lo, size: bus.LOCAL_SIZE} : fifo_mem[rd_ptr];
    end

    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            rd_busy  <= 1'b0;
            rd_addr  <= '0;
            rd_left  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FIFO_CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FIFO_CNT_W'(1);
                default: ;
            endcase
            if (take) begin
                rd_busy <= 1'b1;
                rd_addr <= next_cmd.addr;
                rd_left <= next_cmd.size;
            end else if (rd_busy) begin
                rd_addr <= rd_addr + ram_addr_t'(1);
                rd_left <= rd_left - size_t'(1);
                if (rd_left == size_t'(1)) rd_busy <= 1'b0;
            end
        end
    end

    // NOTE: RAM and FIFO storage carry no reset; occupancy and valid flags are what
    // reset clears, and the RAM deliberately keeps its contents across RST.
    always_ff @(posedge MEM_CLK) begin
        if (ram_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (bus.LOCAL_BE[b]) mem[ram_waddr][b*8 +: 8] <= bus.LOCAL_WDATA[b*8 +: 8];
            end
        end
        if (fifo_wr) fifo_mem[wr_ptr] <= rd_cmd_t'{addr: addr_lo, size: bus.LOCAL_SIZE};
    end

    // Stage 0 is the RAM read register; the last stage only loads on valid data so
    // LOCAL_RDATA holds between bursts.
    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            pipe_valid   <= {pipe_valid[RD_LATENCY-2:0], rd_busy};
            pipe_data[0] <= mem[rd_addr];
            for (int i = 1; i < RD_LATENCY - 1; i++) pipe_data[i] <= pipe_data[i-1];
            if (pipe_valid[RD_LATENCY-2]) pipe_data[RD_LATENCY-1] <= pipe_data[RD_LATENCY-2];
        end
    end

    assign bus.LOCAL_INITIAL_DONE = init_done;
    assign bus.LOCAL_READY        = ready;
    assign bus.LOCAL_RDATA        = pipe_data[RD_LATENCY-1];
    assign bus.LOCAL_RDATA_VALID  = pipe_valid[RD_LATENCY-1];
    assign bus.PROTO_ERR          = proto_err;
endmodule

// File: tb/tb_ddr_local_responder.sv
// Scoreboard bench: read data expected from a bench-side RAM model is queued at command
// accept and compared as beats arrive; two DUTs cover the FF and 0x55 ready patterns.
module tb_ddr_local_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] addr  = '0;
    logic [2:0]  size  = '0;
    logic        bb    = 1'b0;
    logic        wreq  = 1'b0;
    logic        rreq  = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be    = '0;

    ddr_local_responder_if bus_a ();
    ddr_local_responder_if bus_b ();

    ddr_local_responder dut_a (.MEM_CLK(clk), .RST(rst), .bus(bus_a.slave));
    ddr_local_responder #(.READY_PATTERN(8'b0101_0101)) dut_b (.MEM_CLK(clk), .RST(rst), .bus(bus_b.slave));

    assign bus_a.LOCAL_ADDR = addr;  assign bus_b.LOCAL_ADDR = addr;
    assign bus_a.LOCAL_SIZE = size;  assign bus_b.LOCAL_SIZE = size;
    assign bus_a.LOCAL_BURSTBEGIN = bb;   assign bus_b.LOCAL_BURSTBEGIN = bb;
    assign bus_a.LOCAL_WRITE_REQ  = wreq; assign bus_b.LOCAL_WRITE_REQ  = wreq;
    assign bus_a.LOCAL_READ_REQ   = rreq; assign bus_b.LOCAL_READ_REQ   = rreq;
    assign bus_a.LOCAL_WDATA = wdata; assign bus_b.LOCAL_WDATA = wdata;
    assign bus_a.LOCAL_BE    = be;    assign bus_b.LOCAL_BE    = be;

    logic        ready, done, rvalid, perr;
    logic [31:0] rdata;
    assign ready  = sel ? bus_b.LOCAL_READY        : bus_a.LOCAL_READY;
    assign done   = sel ? bus_b.LOCAL_INITIAL_DONE : bus_a.LOCAL_INITIAL_DONE;
    assign rvalid = sel ? bus_b.LOCAL_RDATA_VALID  : bus_a.LOCAL_RDATA_VALID;
    assign rdata  = sel ? bus_b.LOCAL_RDATA        : bus_a.LOCAL_RDATA;
    assign perr   = sel ? bus_b.PROTO_ERR          : bus_a.PROTO_ERR;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model_mem [1024];
    logic [31:0] wbuf [8];
    logic [31:0] sb [$];
    logic [31:0] exp_q;
    bit          mon_en = 1'b0;
    int          beats, first_cyc, last_cyc, acc_cyc, stalls;

    // Beats are compared on the falling edge, half a cycle clear of the DUT update.
    always @(negedge clk) begin
        if (mon_en && rvalid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got %h with nothing outstanding", rdata);
            end else begin
                exp_q = sb.pop_front();
                if (rdata !== exp_q) begin
                    bad++;
                    $display("FAIL rdata: got %h expected %h", rdata, exp_q);
                end
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
        end
    end

    task automatic clear_mon();
        beats = 0; first_cyc = -1; last_cyc = -1; stalls = 0;
    endtask

    // Called at a falling edge; holds the request until READY, returns at the falling edge after accept.
    task automatic send(input bit wr, input bit first, input logic [24:0] a, input logic [2:0] s,
                        input logic [31:0] d, input logic [3:0] b);
        int t = 0;
        addr = a; size = s; bb = first; wreq = wr; rreq = !wr; wdata = d; be = b;
        while (ready !== 1'b1 && t < 500) begin
            stalls++;
            @(negedge clk);
            t++;
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: ready=%b after %0d cycles, required 1", ready, t);
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        wreq = 1'b0; rreq = 1'b0; bb = 1'b0;
    endtask

    task automatic write_burst(input logic [24:0] a, input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) begin
            int ix = (int'(a[9:0]) + i) % 1024;
            send(1'b1, i == 0, a, 3'(n), wbuf[i], b);
            for (int k = 0; k < 4; k++) if (b[k]) model_mem[ix][k*8 +: 8] = wbuf[i][k*8 +: 8];
        end
    endtask

    task automatic read_burst(input logic [24:0] a, input int n);
        send(1'b0, 1'b1, a, 3'(n), '0, '0);
        for (int i = 0; i < n; i++) sb.push_back(model_mem[(int'(a[9:0]) + i) % 1024]);
    endtask

    task automatic read_const(input logic [24:0] a, input logic [31:0] e);
        send(1'b0, 1'b1, a, 3'd1, '0, '0);
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d beats still outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        int t = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        while (done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL init_timeout: done=%b, required 1", done);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total += 5;
        if (done !== 1'b0)   begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
        if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", rvalid); end
        if (rdata !== '0)    begin bad++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        if (perr !== 1'b0)   begin bad++; $display("FAIL rst_proto: got %b expected 0", perr); end
        if (ready !== 1'b0)  begin bad++; $display("FAIL rst_ready: got %b expected 0", ready); end
        rst = 1'b0;
        repeat (16) @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL init_early: done=%b at cycle 16, expected 0", done); end
        @(negedge clk);
        total += 2;
        if (done !== 1'b1)  begin bad++; $display("FAIL init_17: done=%b at cycle 17, expected 1", done); end
        if (ready !== 1'b1) begin bad++; $display("FAIL ready_17: ready=%b at cycle 17, expected 1", ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        int racc;
        clear_mon();
        wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
        write_burst(25'h10, 2, 4'hF);
        read_burst(25'h10, 2);
        racc = acc_cyc;
        wait_drain();
        total += 3;
        if (first_cyc - racc !== 4) begin bad++; $display("FAIL rd_latency: got %0d expected 4", first_cyc - racc); end
        if (beats !== 2) begin bad++; $display("FAIL rd_beats: got %0d expected 2", beats); end
        if (last_cyc - first_cyc !== 1) begin bad++; $display("FAIL rd_span: got %0d expected 1", last_cyc - first_cyc); end
    endtask

    task automatic test_byte_enable();
        wbuf[0] = 32'hFFFFFFFF;
        write_burst(25'h20, 1, 4'hF);
        wbuf[0] = 32'h00000000;
        write_burst(25'h20, 1, 4'b0101);
        read_const(25'h20, 32'hFF00FF00);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) wbuf[i] = 32'h1000_0000 + 32'(i * 32'h01010101);
        write_burst(25'h40, 7, 4'hF);
        for (int i = 0; i < 5; i++) wbuf[i] = 32'h2000_0000 + 32'(i * 32'h00110011);
        write_burst(25'h47, 5, 4'hF);
        clear_mon();
        for (int i = 0; i < 6; i++) read_burst(25'h40 + 25'(2 * i), 2);
        wait_drain();
        total += 3;
        if (beats !== 12) begin bad++; $display("FAIL b2b_beats: got %0d expected 12", beats); end
        if (last_cyc - first_cyc !== 11) begin bad++; $display("FAIL b2b_gapless: span %0d expected 11", last_cyc - first_cyc); end
        if (perr !== 1'b0) begin bad++; $display("FAIL b2b_proto: got %b expected 0", perr); end
    endtask

    task automatic test_fifo_full();
        clear_mon();
        for (int i = 0; i < 5; i++) read_burst(25'h40, 7);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL fifo_full_ready: got %b expected 0", ready); end
        read_burst(25'h41, 7);
        wait_drain();
        total += 2;
        if (beats !== 42) begin bad++; $display("FAIL fifo_beats: got %0d expected 42", beats); end
        if (last_cyc - first_cyc !== 41) begin bad++; $display("FAIL fifo_gapless: span %0d expected 41", last_cyc - first_cyc); end
    endtask

    task automatic test_pattern();
        sel = 1'b1;
        do_reset();
        clear_mon();
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
        write_burst(25'h3FF, 2, 4'hF);
        wbuf[0] = 32'h33333333; wbuf[1] = 32'h44444444; wbuf[2] = 32'h55555555;
        write_burst(25'h100, 3, 4'hF);
        read_burst(25'h3FF, 2);
        read_burst(25'h100, 3);
        read_const(25'h0, 32'h22222222);
        wait_drain();
        total += 2;
        if (stalls == 0) begin bad++; $display("FAIL pattern_stalls: got 0 held cycles, expected >0"); end
        if (perr !== 1'b0) begin bad++; $display("FAIL pattern_proto: got %b expected 0", perr); end
        sel = 1'b0;
        do_reset();
    endtask

    task automatic test_protocol_abuse();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
        write_burst(25'h80, 4, 4'hF);
        total++;
        if (perr !== 1'b0) begin bad++; $display("FAIL abuse_pre: got %b expected 0", perr); end
        send(1'b1, 1'b0, 25'h80, 3'd1, 32'hDEADBEEF, 4'hF);
        total++;
        if (perr !== 1'b1) begin bad++; $display("FAIL abuse_flag: got %b expected 1", perr); end
        read_burst(25'h80, 4);
        wait_drain();
        total++;
        if (perr !== 1'b1) begin bad++; $display("FAIL abuse_sticky: got %b expected 1", perr); end
    endtask

    task automatic test_reset_mid_read();
        int t = 0;
        read_burst(25'h40, 7);
        while (rvalid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (rvalid !== 1'b1) begin bad++; $display("FAIL midrd_start: valid=%b expected 1", rvalid); end
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total += 3;
        if (rvalid !== 1'b0) begin bad++; $display("FAIL midrd_valid: got %b expected 0", rvalid); end
        if (done !== 1'b0)   begin bad++; $display("FAIL midrd_done: got %b expected 0", done); end
        if (perr !== 1'b0)   begin bad++; $display("FAIL midrd_proto: got %b expected 0", perr); end
        sb.delete();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (rvalid !== 1'b0) begin bad++; $display("FAIL midrd_quiet: got %b expected 0", rvalid); end
    endtask

    initial begin
        clear_mon();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_fifo_full();
        test_pattern();
        test_protocol_abuse();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
